// File: rtl/sync_updown_counter_v.sv
// WIDTH-bit synchronous up/down counter with programmable modulus, parallel load,
// CEP/CET enables and a combinational terminal count for ripple cascading.
module sync_updown_counter_v #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             CP,
    input  logic             MRn,
    input  logic             PEn,
    input  logic [WIDTH-1:0] D,
    input  logic             CEP,
    input  logic             CET,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             TC
);

    localparam logic [WIDTH-1:0] MAX_Q     = WIDTH'(MODULUS - 1);
    localparam bit               FULL_SPAN = (64'(MODULUS) == (64'd1 << WIDTH));

    logic [WIDTH-1:0] q_up;
    logic [WIDTH-1:0] q_dn;

    // Full binary span wraps by natural overflow; otherwise wrap at the modulus
    // and pull out-of-range loaded values back into range.
    generate
        if (FULL_SPAN) begin : g_full
            always_comb begin
                q_up = Q + WIDTH'(1);
                q_dn = Q - WIDTH'(1);
            end
        end else begin : g_mod
            always_comb begin
                q_up = (Q >= MAX_Q) ? '0 : Q + WIDTH'(1);
                q_dn = ((Q == '0) || (Q > MAX_Q)) ? MAX_Q : Q - WIDTH'(1);
            end
        end
    endgenerate

    // Clear > load > count > hold
    always_ff @(posedge CP) begin
        if (!MRn) begin
            Q <= '0;
        end else if (!PEn) begin
            Q <= D;
        end else if (CEP && CET) begin
            Q <= UP ? q_up : q_dn;
        end
    end

    // Gated by CET only, so a chain of stages ripples the enable down the line
    assign TC = CET & ((UP & (Q == MAX_Q)) | (~UP & (Q == '0)));

endmodule

// File: tb/tb_sync_updown_counter_v.sv
// Self-checking bench: vector table, randomized run against a behavioural model,
// combinational TC / no-edge clear sequences and a two-stage decade cascade.
module tb_sync_updown_counter_v;

    logic       CP;
    logic       mr, pe, cep, cet, up;
    logic [3:0] d;
    logic [3:0] q10, q16;
    logic       tc10, tc16;

    logic       c_mr, c_pe, c_cep, c_up;
    logic [3:0] c_d;
    logic [3:0] qu, qt;
    logic       tcu, tct;

    int errors = 0;
    int checks = 0;
    int m10 = 0;
    int m16 = 0;

    sync_updown_counter_v #(.WIDTH(4), .MODULUS(10)) dut10 (
        .CP(CP), .MRn(mr), .PEn(pe), .D(d), .CEP(cep), .CET(cet), .UP(up),
        .Q(q10), .TC(tc10));

    sync_updown_counter_v #(.WIDTH(4), .MODULUS(16)) dut16 (
        .CP(CP), .MRn(mr), .PEn(pe), .D(d), .CEP(cep), .CET(cet), .UP(up),
        .Q(q16), .TC(tc16));

    sync_updown_counter_v #(.WIDTH(4), .MODULUS(10)) units (
        .CP(CP), .MRn(c_mr), .PEn(c_pe), .D(c_d), .CEP(c_cep), .CET(1'b1), .UP(c_up),
        .Q(qu), .TC(tcu));

    sync_updown_counter_v #(.WIDTH(4), .MODULUS(10)) tens (
        .CP(CP), .MRn(c_mr), .PEn(c_pe), .D(c_d), .CEP(c_cep), .CET(tcu), .UP(c_up),
        .Q(qt), .TC(tct));

    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    typedef struct {
        bit       mr, pe, cep, cet, up;
        int       d;
        int       q;
        bit       tc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit mr_i, bit pe_i, int d_i, bit cep_i, bit cet_i, bit up_i,
                                int q_i, bit tc_i);
        vec_t v;
        v.mr = mr_i; v.pe = pe_i; v.d = d_i; v.cep = cep_i; v.cet = cet_i; v.up = up_i;
        v.q = q_i; v.tc = tc_i;
        return v;
    endfunction

    // Behavioural rule set: value arithmetic on plain integers
    function automatic int model_next(int q, int m, bit mr_i, bit pe_i, int d_i,
                                      bit cep_i, bit cet_i, bit up_i);
        if (!mr_i) return 0;
        if (!pe_i) return d_i;
        if (!(cep_i && cet_i)) return q;
        if (up_i) return (q >= m - 1) ? 0 : q + 1;
        if (q == 0 || q > m - 1) return m - 1;
        return q - 1;
    endfunction

    function automatic bit model_tc(int q, int m, bit cet_i, bit up_i);
        return cet_i && (up_i ? (q == m - 1) : (q == 0));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drv(input bit mr_i, input bit pe_i, input int d_i,
                       input bit cep_i, input bit cet_i, input bit up_i);
        mr = mr_i; pe = pe_i; d = 4'(d_i); cep = cep_i; cet = cet_i; up = up_i;
    endtask

    // One rising edge on the single-counter pair; models advance with it
    task automatic step();
        @(posedge CP);
        m10 = model_next(m10, 10, mr, pe, int'(d), cep, cet, up);
        m16 = model_next(m16, 16, mr, pe, int'(d), cep, cet, up);
        #1;
        chk("q_mod16", int'(q16), m16);
        chk("tc_mod16", int'(tc16), int'(model_tc(m16, 16, cet, up)));
    endtask

    initial begin
        int v;
        drv(1, 1, 0, 0, 0, 1);
        c_mr = 1'b1; c_pe = 1'b1; c_d = '0; c_cep = 1'b0; c_up = 1'b1;
        #1;

        // Reset then up-count through the decade wrap
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 0));
        for (int i = 1; i <= 12; i++)
            vecs.push_back(mk(1, 1, 0, 1, 1, 1, i % 10, (i % 10) == 9));
        // Load 3, count down through 0 -> 9
        vecs.push_back(mk(1, 0, 3, 1, 1, 0, 3, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 2, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 9, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 8, 0));
        // Clear beats load; load beats disabled count
        vecs.push_back(mk(0, 0, 7, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 7, 0, 0, 1, 7, 0));
        // Enables
        vecs.push_back(mk(1, 0, 5, 0, 1, 1, 5, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 0, 1, 1, 5, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 1, 0, 1, 5, 0));
        vecs.push_back(mk(1, 0, 9, 1, 0, 1, 9, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 1, 9, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 9, 1));
        // Out-of-range load recovery in both directions
        vecs.push_back(mk(1, 0, 13, 1, 1, 1, 13, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 13, 1, 1, 0, 13, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 9, 0));

        foreach (vecs[i]) begin
            drv(vecs[i].mr, vecs[i].pe, vecs[i].d, vecs[i].cep, vecs[i].cet, vecs[i].up);
            step();
            chk($sformatf("vec%0d_q", i), int'(q10), vecs[i].q);
            chk($sformatf("vec%0d_tc", i), int'(tc10), int'(vecs[i].tc));
        end

        // TC follows UP/CET combinationally; MRn without an edge does nothing
        drv(0, 1, 0, 1, 1, 1);
        step();
        drv(1, 1, 0, 0, 1, 1);
        #1 chk("tc_up_at0", int'(tc10), 0);
        up = 1'b0;
        #1 chk("tc_down_at0", int'(tc10), 1);
        cet = 1'b0;
        #1 chk("tc_cet_off", int'(tc10), 0);
        drv(1, 0, 6, 0, 0, 1);
        step();
        mr = 1'b0;
        #2 chk("no_edge_clear", int'(q10), 6);
        mr = 1'b1;
        drv(1, 1, 0, 0, 0, 1);
        step();
        chk("hold_after_mr_glitch", int'(q10), 6);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            drv($urandom_range(15) != 0, $urandom_range(7) != 0, $urandom_range(15),
                $urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(1));
            step();
            chk("rand_q", int'(q10), m10);
            chk("rand_tc", int'(tc10), int'(model_tc(m10, 10, cet, up)));
            up = ~up;
            #1 chk("rand_tc_flip", int'(tc10), int'(model_tc(m10, 10, cet, up)));
        end

        // Two-stage decade cascade: one counter of modulus 100
        c_mr = 1'b0;
        @(posedge CP); #1;
        c_mr = 1'b1; c_cep = 1'b1; c_up = 1'b1;
        v = 0;
        chk("casc_reset", int'(qt) * 10 + int'(qu), 0);
        for (int i = 0; i < 100; i++) begin
            @(posedge CP); #1;
            v = (v + 1) % 100;
            chk("casc_up", int'(qt) * 10 + int'(qu), v);
            chk("casc_up_tc", int'(tct), int'(v == 99));
        end
        c_up = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CP); #1;
            v = (v + 99) % 100;
            chk("casc_dn", int'(qt) * 10 + int'(qu), v);
            chk("casc_dn_tc", int'(tct), int'(v == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
